mem_initiator: RTL and testbench

Bus-master counterpart to the memory responder. It accepts read/write commands from a local command port into a small FIFO and issues them one at a time on the memory valid/ready bus. It returns one response per command, carrying read data or write completion. It sits between test or system logic and the memory, as synthesizable RTL.

---
 rtl/mem_initiator.sv | 164 ++++++++++++++++
 tb/tb_mem_initiator.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// Bus-master that queues local read/write commands in a small FIFO and issues them
// one at a time on a valid/ready memory bus, returning one response per command.
module mem_initiator #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_wr_rd,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wr_rd,
    output logic                  valid,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [15:0]           done_count
);

    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    logic [EW-1:0]         fifoMem_q [CMD_DEPTH];
    logic [PW-1:0]         wrPtr_q;
    logic [PW-1:0]         rdPtr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [EW-1:0]         head;

    state_t                state_q;
    logic [TW-1:0]         timer_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wrRd_q;
    logic                  valid_q;
    logic                  rspValid_q;
    logic                  rspWrRd_q;
    logic [ADDR_WIDTH-1:0] rspAddr_q;
    logic [DATA_WIDTH-1:0] rspRdata_q;
    logic                  rspErr_q;
    logic [15:0]           doneCount_q;

    // cmd_ready comes only from the registered occupancy, so a same-cycle pop never admits a push
    assign full      = (count_q == CW'(CMD_DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state_q == IDLE) && !empty;
    assign head      = fifoMem_q[rdPtr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {cmd_wr_rd, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + PW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // A response is loaded on leaving REQ, so rsp_valid is high exactly during the RSP cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wrRd_q      <= 1'b0;
            valid_q     <= 1'b0;
            rspValid_q  <= 1'b0;
            rspWrRd_q   <= 1'b0;
            rspAddr_q   <= '0;
            rspRdata_q  <= '0;
            rspErr_q    <= 1'b0;
            doneCount_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        {wrRd_q, addr_q, wdata_q} <= head;
                        timer_q <= '0;
                        valid_q <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (ready) begin
                        valid_q     <= 1'b0;
                        rspValid_q  <= 1'b1;
                        rspWrRd_q   <= wrRd_q;
                        rspAddr_q   <= addr_q;
                        rspRdata_q  <= wrRd_q ? '0 : rdata;
                        rspErr_q    <= 1'b0;
                        doneCount_q <= doneCount_q + 16'd1;
                        state_q     <= RSP;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        valid_q     <= 1'b0;
                        rspValid_q  <= 1'b1;
                        rspWrRd_q   <= wrRd_q;
                        rspAddr_q   <= addr_q;
                        rspRdata_q  <= '0;
                        rspErr_q    <= 1'b1;
                        doneCount_q <= doneCount_q + 16'd1;
                        state_q     <= RSP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RSP: begin
                    rspValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign wr_rd      = wrRd_q;
    assign valid      = valid_q;
    assign rsp_valid  = rspValid_q;
    assign rsp_wr_rd  = rspWrRd_q;
    assign rsp_addr   = rspAddr_q;
    assign rsp_rdata  = rspRdata_q;
    assign rsp_err    = rspErr_q;
    assign done_count = doneCount_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: drives commands, models a simple responder memory,
// and checks bus timing, responses, FIFO backpressure, timeout and reset behaviour.
module tb_mem_initiator;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr_rd;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_wr_rd;
    logic [3:0]  rsp_addr;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic        wr_rd;
    logic        valid;
    logic        ready;
    logic [7:0]  rdata;
    logic [15:0] done_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] memModel [16] = '{9: 8'h3C, default: 8'h00};

    mem_initiator #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(8),
        .CMD_DEPTH (4),
        .TIMEOUT   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr_rd (cmd_wr_rd),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_wr_rd (rsp_wr_rd),
        .rsp_addr  (rsp_addr),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .addr      (addr),
        .wdata     (wdata),
        .wr_rd     (wr_rd),
        .valid     (valid),
        .ready     (ready),
        .rdata     (rdata),
        .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder memory: combinational read, write committed in the handshake cycle
    assign rdata = memModel[addr];
    always @(negedge clk) begin
        if (valid && ready && wr_rd) memModel[addr] <= wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [3:0] a, input logic [7:0] d);
        checkOutput("cmd_ready_before_push", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_wr_rd = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic applyReset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        ready     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic waitRsp(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_valid && n < 40);
        checkOutput(tag, rsp_valid, 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int rspSeen;
        int validSeen;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr_rd = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        ready     = 1'b0;
        tick();
        tick();

        // Reset state
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_done_count", done_count, 0);
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;

        // Single write, ready tied high
        ready = 1'b1;
        applyStimulus(1'b1, 4'd3, 8'hA5);
        checkOutput("w1_valid_lat1", valid, 0);
        tick();
        checkOutput("w1_valid", valid, 1);
        checkOutput("w1_addr", addr, 3);
        checkOutput("w1_wr_rd", wr_rd, 1);
        checkOutput("w1_wdata", wdata, 8'hA5);
        tick();
        checkOutput("w1_rsp_valid", rsp_valid, 1);
        checkOutput("w1_rsp_wr_rd", rsp_wr_rd, 1);
        checkOutput("w1_rsp_err", rsp_err, 0);
        checkOutput("w1_rsp_addr", rsp_addr, 3);
        checkOutput("w1_rsp_rdata", rsp_rdata, 0);
        checkOutput("w1_valid_drop", valid, 0);
        tick();
        checkOutput("w1_rsp_pulse_end", rsp_valid, 0);
        checkOutput("w1_done_count", done_count, 1);

        // Write then read back the same address
        applyReset();
        ready = 1'b1;
        applyStimulus(1'b1, 4'd7, 8'h5A);
        applyStimulus(1'b0, 4'd7, 8'h00);
        waitRsp("wr_rsp_seen");
        checkOutput("wr_rsp_wr_rd", rsp_wr_rd, 1);
        checkOutput("wr_rsp_addr", rsp_addr, 7);
        waitRsp("rd_rsp_seen");
        checkOutput("rd_rsp_wr_rd", rsp_wr_rd, 0);
        checkOutput("rd_rsp_addr", rsp_addr, 7);
        checkOutput("rd_rsp_rdata", rsp_rdata, 8'h5A);
        checkOutput("rd_rsp_err", rsp_err, 0);
        tick();
        checkOutput("wr_rd_done_count", done_count, 2);

        // Timeout with ready low, then a queued read completes normally
        applyReset();
        applyStimulus(1'b0, 4'd9, 8'h00);
        applyStimulus(1'b0, 4'd9, 8'h00);
        n = 0;
        while (valid === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checkOutput("to_valid_cycles", n, 16);
        checkOutput("to_rsp_valid", rsp_valid, 1);
        checkOutput("to_rsp_err", rsp_err, 1);
        checkOutput("to_rsp_rdata", rsp_rdata, 0);
        checkOutput("to_rsp_addr", rsp_addr, 9);
        ready = 1'b1;
        waitRsp("to_next_rsp_seen");
        checkOutput("to_next_err", rsp_err, 0);
        checkOutput("to_next_rdata", rsp_rdata, 8'h3C);
        checkOutput("to_done_count", done_count, 2);

        // Five back-to-back commands with ready low fill the FIFO
        applyReset();
        applyStimulus(1'b1, 4'd1, 8'h11);
        applyStimulus(1'b1, 4'd2, 8'h22);
        applyStimulus(1'b0, 4'd1, 8'h00);
        applyStimulus(1'b0, 4'd2, 8'h00);
        applyStimulus(1'b1, 4'd4, 8'h44);
        checkOutput("full_cmd_ready", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_wr_rd = 1'b1;
        cmd_addr  = 4'hF;
        cmd_wdata = 8'hFF;
        tick();
        tick();
        checkOutput("full_ignores_push", cmd_ready, 0);
        cmd_valid = 1'b0;
        ready = 1'b1;
        waitRsp("q0_seen");
        checkOutput("q0_addr", rsp_addr, 1);
        checkOutput("q0_wr_rd", rsp_wr_rd, 1);
        checkOutput("q0_full_in_rsp", cmd_ready, 0);
        tick();
        checkOutput("q0_full_on_pop", cmd_ready, 0);
        tick();
        checkOutput("q0_ready_after_pop", cmd_ready, 1);
        waitRsp("q1_seen");
        checkOutput("q1_addr", rsp_addr, 2);
        checkOutput("q1_wr_rd", rsp_wr_rd, 1);
        waitRsp("q2_seen");
        checkOutput("q2_addr", rsp_addr, 1);
        checkOutput("q2_rdata", rsp_rdata, 8'h11);
        waitRsp("q3_seen");
        checkOutput("q3_addr", rsp_addr, 2);
        checkOutput("q3_rdata", rsp_rdata, 8'h22);
        waitRsp("q4_seen");
        checkOutput("q4_addr", rsp_addr, 4);
        checkOutput("q4_wr_rd", rsp_wr_rd, 1);
        rspSeen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid) rspSeen++;
        end
        checkOutput("q_no_extra_rsp", rspSeen, 0);
        checkOutput("q_done_count", done_count, 5);

        // Ready delayed: request fields stable, handshake on the 4th valid cycle
        applyReset();
        applyStimulus(1'b1, 4'd5, 8'h77);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("dly_valid", valid, 1);
            checkOutput("dly_addr", addr, 5);
            checkOutput("dly_wdata", wdata, 8'h77);
            checkOutput("dly_wr_rd", wr_rd, 1);
            if (i == 3) ready = 1'b1;
            tick();
        end
        checkOutput("dly_rsp_valid", rsp_valid, 1);
        checkOutput("dly_rsp_err", rsp_err, 0);
        checkOutput("dly_rsp_addr", rsp_addr, 5);
        checkOutput("dly_valid_drop", valid, 0);
        checkOutput("dly_done_count", done_count, 1);

        // Reset asserted mid-request
        ready = 1'b0;
        tick();
        applyStimulus(1'b0, 4'd6, 8'h00);
        applyStimulus(1'b1, 4'd8, 8'h99);
        checkOutput("mid_valid_pre", valid, 1);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("mid_valid_async", valid, 0);
        checkOutput("mid_cmd_ready", cmd_ready, 1);
        checkOutput("mid_done_count", done_count, 0);
        tick();
        rst   = 1'b0;
        ready = 1'b1;
        rspSeen   = 0;
        validSeen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid) rspSeen++;
            if (valid) validSeen++;
        end
        checkOutput("mid_no_rsp", rspSeen, 0);
        checkOutput("mid_no_valid", validSeen, 0);
        checkOutput("mid_done_after", done_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
